// File: rtl/alu_seq.sv
// Handshaked, registered ALU: single-cycle logic/arith/shift ops plus a
// fixed-latency shift-add multiply, with results held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] LAST_COUNT = (SHW+1)'(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_BLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW:0]     count;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

    // Single-cycle operations; BLT encodes "taken" as a zero result.
    function automatic logic [WIDTH-1:0] alu_eval(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [3:0]       code
    );
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [SHW-1:0]          sh;
        xs = x;
        ys = y;
        sh = y[SHW-1:0];
        case (code)
            OP_AND:  alu_eval = x & y;
            OP_OR:   alu_eval = x | y;
            OP_ADD:  alu_eval = x + y;
            OP_SUB:  alu_eval = x - y;
            OP_NOR:  alu_eval = ~(x | y);
            OP_NAND: alu_eval = ~(x & y);
            OP_SLL:  alu_eval = x << sh;
            OP_SRL:  alu_eval = x >> sh;
            OP_SRA:  alu_eval = xs >>> sh;
            OP_BLT:  alu_eval = (xs < ys) ? '0 : WIDTH'(1);
            default: alu_eval = '0;
        endcase
    endfunction

    assign accept  = in_valid && in_ready;
    assign alu_res = alu_eval(a, b, op);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (op == OP_MUL) begin
                            mcand  <= a;
                            mplier <= b;
                            acc    <= '0;
                            count  <= '0;
                            state  <= S_MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    // All WIDTH iterations always run so latency never depends on data.
                    if (count == LAST_COUNT) begin
                        result    <= acc;
                        zero      <= (acc == '0);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + (SHW+1)'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=64): each op, multiply latency, backpressure and reset.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;

    int compared;
    int mismatched;

    alu_seq #(.WIDTH(64)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .op(op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue a single-cycle op with out_ready=1 and check its registered result.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] er, input logic ez);
        op = o; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, zero, ez);
        step();
        check({tag, ".ready"}, in_ready, 1);
    endtask

    task automatic run_mul(input string tag, input logic [63:0] x, input logic [63:0] y,
                           input logic [63:0] er, input logic ez);
        int cycles;
        logic ready_seen;
        op = 4'b0011; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cycles = 0;
        ready_seen = 1'b0;
        while (!out_valid && cycles < 200) begin
            if (in_ready) ready_seen = 1'b1;
            step();
            cycles++;
        end
        check({tag, ".latency"}, 64'(cycles), 64'd65);
        check({tag, ".ready_low"}, ready_seen, 0);
        check({tag, ".result"}, result, er);
        check({tag, ".zero"}, zero, ez);
        step();
        check({tag, ".ready"}, in_ready, 1);
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        op = '0;
        step();
        step();
        check("rst.ready", in_ready, 1);
        check("rst.valid", out_valid, 0);
        check("rst.result", result, 0);
        check("rst.zero", zero, 1);
        reset = 1'b0;
        step();

        run_op("add", 4'b0010, 64'd5, 64'd7, 64'd12, 1'b0);
        run_op("sub", 4'b0110, 64'd7, 64'd7, 64'd0, 1'b1);
        run_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 1'b0);
        run_op("blt_taken", 4'b0111, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 64'd0, 1'b1);
        run_op("blt_not", 4'b0111, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0);
        run_op("sra", 4'b1010, 64'h8000_0000_0000_0000, 64'h1_0000_0004,
               64'hF800_0000_0000_0000, 1'b0);
        run_op("srl", 4'b1001, 64'h8000_0000_0000_0000, 64'h1_0000_0004,
               64'h0800_0000_0000_0000, 1'b0);
        run_op("sll", 4'b1000, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0);
        run_op("and", 4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0);
        run_op("or", 4'b0001, 64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0);
        run_op("nor", 4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("nand", 4'b1101, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        run_op("bad_op", 4'b0100, 64'hFF, 64'hFF, 64'd0, 1'b1);

        run_mul("mul", 64'd123456, 64'd1000, 64'd123456000, 1'b0);
        run_mul("mul_wrap", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1);

        // Result must hold while the consumer stalls; inputs are ignored meanwhile.
        out_ready = 1'b0;
        op = 4'b0010; a = 64'd3; b = 64'd4; in_valid = 1'b1;
        step();
        op = 4'b0110; a = 64'd100; b = 64'd1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            step();
            check("bp.valid", out_valid, 1);
            check("bp.result", result, 64'd7);
            check("bp.ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp.release_ready", in_ready, 1);
        check("bp.release_valid", out_valid, 0);

        // Abort a multiply mid-flight.
        op = 4'b0011; a = 64'd3; b = 64'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort.ready", in_ready, 1);
        check("abort.valid", out_valid, 0);
        check("abort.result", result, 0);
        check("abort.zero", zero, 1);
        repeat (70) begin
            step();
            if (out_valid) break;
        end
        check("abort.no_emit", out_valid, 0);
        run_op("after_abort", 4'b0010, 64'd1, 64'd1, 64'd2, 1'b0);

        // Reset beats a simultaneous accept.
        op = 4'b0010; a = 64'd5; b = 64'd5; in_valid = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        check("rst_vs_acc.valid", out_valid, 0);
        check("rst_vs_acc.result", result, 0);
        check("rst_vs_acc.ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
